servo_pwm_decoder: RTL and testbench
====================================

Name: servo_pwm_decoder

Overview:
- Receive-side counterpart of the servo PWM generator. Measures an incoming hobby-servo PWM waveform (servo_pwm looped back, or an external servo line) in 1 us resolution.
- Recovers the commanded 4-bit speed level and flags range, period and timeout faults.
- Sits beside rpm_ctrl in the top so the dashboard can self-check that the gauge command actually leaves the chip.

Parameters:
- TICK_DIV, 100, clk cycles per 1 us measurement tick.
- MIN_US, 1000, pulse width for level 0.
- STEP_US, 64, pulse-width increment per level.
- LEVEL_MAX, 15, highest valid level.
- PERIOD_US, 20000, nominal frame period.
- PERIOD_TOL_US, 2000, allowed period deviation (inclusive).

Ports:
- clk_100mhz  input  1  system clock
- rst  input  1  synchronous active-high reset
- pwm_in  input  1  asynchronous PWM input
- level  output  4  last successfully decoded level
- pulse_us  output  12  last measured high time in us (saturating)
- period_us  output  15  last measured period in us (saturating)
- level_valid  output  1  one-cycle strobe when level/pulse_us/period_us update
- err_range  output  1  one-cycle strobe: pulse outside decodable window
- err_period  output  1  one-cycle strobe: period outside PERIOD_US±PERIOD_TOL_US
- timeout  output  1  level flag: no rising edge for 2*PERIOD_US
- locked  output  1  level flag: last frame decoded without error

Behaviour:
- Reset: level=0, pulse_us=0, period_us=0, all strobes 0, timeout=0, locked=0, FSM=IDLE, prescaler and counters cleared. Reset mid-measurement discards the frame.
- Input path: 2-FF synchronizer, then edge detector on the synchronized value. Rise/fall are seen 2–3 clk after the pin changes.
- Prescaler: free-running 0..TICK_DIV-1; tick when it equals TICK_DIV-1. Widths are counted in ticks, so measurement error is ±1 us.
- Counters: hi_cnt and per_cnt both saturate at their all-ones value; no wrap.
- IDLE: wait for rise. A line that is already high after reset is ignored until it has fallen and risen again. On rise: clear hi_cnt and per_cnt, go to HIGH.
- HIGH: per_cnt and hi_cnt increment per tick. Fall goes to LOW.
- LOW: per_cnt increments per tick. Rise ends the frame.
- Frame end:
  - Latch hi_cnt/per_cnt into holding regs and start the calc engine.
  - In the same cycle, clear the counters and go to HIGH, so the next frame is measured back-to-back with no lost edge.
- Calc engine (independent of the FSM):
  - Let w = held pulse + STEP_US/2.
  - If w < MIN_US, or w ≥ MIN_US + (LEVEL_MAX+1)*STEP_US → err_range.
  - Otherwise compute (w−MIN_US)/STEP_US by repeated subtraction, one per clk, at most LEVEL_MAX+1 iterations.
  - Period check runs in parallel: period outside the tolerance → err_period.
- Result, emitted exactly LEVEL_MAX+3 clk after the frame-end rise is detected (fixed latency):
  - No error: update level, pulse_us, period_us; pulse level_valid; locked=1.
  - Any error: pulse the corresponding strobe(s) for 1 clk, update only pulse_us/period_us, leave level unchanged, locked=0. level_valid is not asserted.
- Back-to-back frames: a frame end while calc is busy is impossible for a legal period. If it happens, the new frame aborts calc, the old result is dropped, err_period pulses, and calc restarts.
- Timeout:
  - per_cnt reaching 2*PERIOD_US in HIGH or LOW sets timeout=1, clears locked, and goes to IDLE.
  - timeout clears on the next rise. level is held.
- No strobe is ever produced from the first rise after reset/IDLE; at least one complete frame is required.

Test Plan:
- 1500 us high / 20000 us period, 3 frames → first level_valid after frame 2, level=8, pulse_us=1500±1, period_us=20000±1, locked=1; one strobe per frame thereafter.
- Sweep 1000 us, 1960 us, 1031 us, 1033 us pulses → level=0, 15, 0, 1 respectively (rounding boundary at MIN_US + STEP_US/2).
- 2100 us pulse after a level-8 frame → err_range 1 clk, level stays 8, locked=0, pulse_us=2100; next 1500 us frame → locked=1.
- Period 10000 us with 1500 us pulse → err_period, level unchanged; period 22000 us → accepted; 22002 us → err_period.
- pwm_in held low 45 ms after lock → timeout=1 at 40000±1 us after the last rise, locked=0, level held; next rise clears timeout and no strobe follows for that first frame.
- rst asserted mid-HIGH while pwm_in is high → all outputs zero; decoder waits for fall+rise; first strobe after two full frames.

Source files
------------

// File: rtl/servo_pwm_decoder.sv
// Measures an incoming hobby-servo PWM line in microsecond ticks and recovers
// the commanded speed level, with range, period and timeout fault reporting.
module servo_pwm_decoder #(
  parameter int TICK_DIV      = 100,
  parameter int MIN_US        = 1000,
  parameter int STEP_US       = 64,
  parameter int LEVEL_MAX     = 15,
  parameter int PERIOD_US     = 20000,
  parameter int PERIOD_TOL_US = 2000
) (
  input  logic        clk_100mhz,
  input  logic        rst,
  input  logic        pwm_in,
  output logic [3:0]  level,
  output logic [11:0] pulse_us,
  output logic [14:0] period_us,
  output logic        level_valid,
  output logic        err_range,
  output logic        err_period,
  output logic        timeout,
  output logic        locked
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX     = PW'(TICK_DIV - 1);
  localparam logic [15:0]   TIMEOUT_TICKS = 16'(2 * PERIOD_US);
  localparam logic [15:0]   PER_LO        = 16'(PERIOD_US - PERIOD_TOL_US);
  localparam logic [15:0]   PER_HI        = 16'(PERIOD_US + PERIOD_TOL_US);
  localparam logic [12:0]   HALF_STEP     = 13'(STEP_US / 2);
  localparam logic [12:0]   STEP_W        = 13'(STEP_US);
  localparam logic [12:0]   W_LO          = 13'(MIN_US);
  localparam logic [12:0]   W_HI          = 13'(MIN_US + (LEVEL_MAX + 1) * STEP_US);
  localparam logic [4:0]    CALC_LAST     = 5'(LEVEL_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_e;

  function automatic logic [14:0] sat15(input logic [15:0] v);
    logic [14:0] r;
    if (v[15]) begin
      r = 15'h7FFF;
    end else begin
      r = v[14:0];
    end
    return r;
  endfunction

  state_e        state_q, state_d;
  logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [11:0]   hi_q, hi_d, hi_inc;
  logic [15:0]   per_q, per_d, per_inc;
  logic          calc_busy_q, calc_busy_d;
  logic [4:0]    calc_cnt_q, calc_cnt_d;
  logic [12:0]   rem_q, rem_d, w_s;
  logic [3:0]    lvl_q, lvl_d;
  logic          rng_q, rng_d, perr_q, perr_d;
  logic [11:0]   hold_hi_q, hold_hi_d;
  logic [15:0]   hold_per_q, hold_per_d;
  logic [3:0]    level_q, level_d;
  logic [11:0]   pulse_q, pulse_d;
  logic [14:0]   period_q, period_d;
  logic          valid_q, valid_d, erng_q, erng_d, eper_q, eper_d;
  logic          tmo_q, tmo_d, locked_q, locked_d;
  logic          rise_s, fall_s, tick_s, start_s, abort_s, done_s, to_fire_s;

  // Input synchronizer, edge detect and microsecond prescaler.
  always_comb begin
    sync1_d = pwm_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise_s  = sync2_q & ~prev_q;
    fall_s  = ~sync2_q & prev_q;
    tick_s  = (presc_q == PRESC_MAX);
    if (tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  // Frame measurement FSM; a rise in LOW both ends one frame and opens the next.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    per_d     = per_q;
    start_s   = 1'b0;
    to_fire_s = 1'b0;
    if (hi_q == 12'hFFF) begin
      hi_inc = hi_q;
    end else begin
      hi_inc = hi_q + 12'd1;
    end
    if (per_q == 16'hFFFF) begin
      per_inc = per_q;
    end else begin
      per_inc = per_q + 16'd1;
    end
    case (state_q)
      S_IDLE: begin
        if (rise_s) begin
          state_d = S_HIGH;
          hi_d    = 12'd0;
          per_d   = 16'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HIGH: begin
        if (per_q >= TIMEOUT_TICKS) begin
          state_d   = S_IDLE;
          to_fire_s = 1'b1;
        end else begin
          if (tick_s) begin
            hi_d  = hi_inc;
            per_d = per_inc;
          end else begin
            hi_d  = hi_q;
          end
          if (fall_s) begin
            state_d = S_LOW;
          end else begin
            state_d = S_HIGH;
          end
        end
      end
      S_LOW: begin
        if (rise_s) begin
          start_s = 1'b1;
          hi_d    = 12'd0;
          per_d   = 16'd0;
          state_d = S_HIGH;
        end else if (per_q >= TIMEOUT_TICKS) begin
          state_d   = S_IDLE;
          to_fire_s = 1'b1;
        end else if (tick_s) begin
          per_d = per_inc;
        end else begin
          per_d = per_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Calc engine: rounded level by repeated subtraction, fixed-length run.
  always_comb begin
    calc_busy_d = calc_busy_q;
    calc_cnt_d  = calc_cnt_q;
    rem_d       = rem_q;
    lvl_d       = lvl_q;
    rng_d       = rng_q;
    perr_d      = perr_q;
    hold_hi_d   = hold_hi_q;
    hold_per_d  = hold_per_q;
    abort_s     = 1'b0;
    done_s      = 1'b0;
    w_s         = {1'b0, hi_q} + HALF_STEP;
    if (start_s) begin
      abort_s     = calc_busy_q;
      calc_busy_d = 1'b1;
      calc_cnt_d  = 5'd0;
      hold_hi_d   = hi_q;
      hold_per_d  = per_q;
      lvl_d       = 4'd0;
      rng_d       = (w_s < W_LO) || (w_s >= W_HI);
      perr_d      = (per_q < PER_LO) || (per_q > PER_HI);
      if ((w_s < W_LO) || (w_s >= W_HI)) begin
        rem_d = 13'd0;
      end else begin
        rem_d = w_s - W_LO;
      end
    end else if (calc_busy_q) begin
      if (rem_q >= STEP_W) begin
        rem_d = rem_q - STEP_W;
        lvl_d = lvl_q + 4'd1;
      end else begin
        rem_d = rem_q;
      end
      if (calc_cnt_q == CALC_LAST) begin
        calc_busy_d = 1'b0;
        done_s      = 1'b1;
      end else begin
        calc_cnt_d  = calc_cnt_q + 5'd1;
      end
    end else begin
      calc_busy_d = 1'b0;
    end
  end

  // Registered result, strobes and status flags.
  always_comb begin
    level_d  = level_q;
    pulse_d  = pulse_q;
    period_d = period_q;
    valid_d  = 1'b0;
    erng_d   = 1'b0;
    eper_d   = 1'b0;
    tmo_d    = tmo_q;
    locked_d = locked_q;
    if (abort_s) begin
      eper_d   = 1'b1;
      locked_d = 1'b0;
    end else if (done_s) begin
      pulse_d  = hold_hi_q;
      period_d = sat15(hold_per_q);
      if (rng_q || perr_q) begin
        erng_d   = rng_q;
        eper_d   = perr_q;
        locked_d = 1'b0;
      end else begin
        level_d  = lvl_q;
        valid_d  = 1'b1;
        locked_d = 1'b1;
      end
    end else begin
      valid_d = 1'b0;
    end
    if (to_fire_s) begin
      tmo_d    = 1'b1;
      locked_d = 1'b0;
    end else if (rise_s) begin
      tmo_d = 1'b0;
    end else begin
      tmo_d = tmo_q;
    end
  end

  // Sync flops reset high so a line already high at reset never looks like a rise.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      presc_q     <= '0;
      hi_q        <= 12'd0;
      per_q       <= 16'd0;
      calc_busy_q <= 1'b0;
      calc_cnt_q  <= 5'd0;
      rem_q       <= 13'd0;
      lvl_q       <= 4'd0;
      rng_q       <= 1'b0;
      perr_q      <= 1'b0;
      hold_hi_q   <= 12'd0;
      hold_per_q  <= 16'd0;
      level_q     <= 4'd0;
      pulse_q     <= 12'd0;
      period_q    <= 15'd0;
      valid_q     <= 1'b0;
      erng_q      <= 1'b0;
      eper_q      <= 1'b0;
      tmo_q       <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      presc_q     <= presc_d;
      hi_q        <= hi_d;
      per_q       <= per_d;
      calc_busy_q <= calc_busy_d;
      calc_cnt_q  <= calc_cnt_d;
      rem_q       <= rem_d;
      lvl_q       <= lvl_d;
      rng_q       <= rng_d;
      perr_q      <= perr_d;
      hold_hi_q   <= hold_hi_d;
      hold_per_q  <= hold_per_d;
      level_q     <= level_d;
      pulse_q     <= pulse_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      erng_q      <= erng_d;
      eper_q      <= eper_d;
      tmo_q       <= tmo_d;
      locked_q    <= locked_d;
    end
  end

  assign level       = level_q;
  assign pulse_us    = pulse_q;
  assign period_us   = period_q;
  assign level_valid = valid_q;
  assign err_range   = erng_q;
  assign err_period  = eper_q;
  assign timeout     = tmo_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Scoreboard bench for servo_pwm_decoder with scaled-down timing parameters.
module tb_servo_pwm_decoder;

  localparam int TD   = 2;
  localparam int MIN  = 100;
  localparam int STEP = 8;
  localparam int LMAX = 15;
  localparam int PER  = 400;
  localparam int TOL  = 40;
  localparam int LAT  = 2 + LMAX + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        pwm_in;
  logic [3:0]  level;
  logic [11:0] pulse_us;
  logic [14:0] period_us;
  logic        level_valid, err_range, err_period, timeout, locked;

  servo_pwm_decoder #(
    .TICK_DIV(TD), .MIN_US(MIN), .STEP_US(STEP), .LEVEL_MAX(LMAX),
    .PERIOD_US(PER), .PERIOD_TOL_US(TOL)
  ) dut (
    .clk_100mhz(clk), .rst(rst), .pwm_in(pwm_in), .level(level),
    .pulse_us(pulse_us), .period_us(period_us), .level_valid(level_valid),
    .err_range(err_range), .err_period(err_period), .timeout(timeout),
    .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] strb;
    int         lvl;
    int         h;
    int         p;
    bit         lock;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   edge_cnt = 0;
  int   model_level = 0;
  bit   pend_v = 1'b0;
  int   pend_h, pend_p;
  int   last_rise = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input bit ok, input int act, input int exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Reference rules: rounded level window and period tolerance.
  function automatic void classify(input int h, input int p, output bit rng,
                                   output bit perr, output int lvl);
    int w;
    w    = h + STEP / 2;
    rng  = (w < MIN) || (w >= MIN + (LMAX + 1) * STEP);
    lvl  = rng ? 0 : (w - MIN) / STEP;
    perr = (p < PER - TOL) || (p > PER + TOL);
  endfunction

  // True when a +-1 us measurement error cannot change the outcome.
  function automatic bit stable(input int h, input int p);
    bit r0, p0, r1, p1;
    int l0, l1;
    classify(h, p, r0, p0, l0);
    for (int d = -1; d <= 1; d++) begin
      classify(h + d, p + d, r1, p1, l1);
      if (r1 != r0 || p1 != p0 || l1 != l0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic push_exp(input int h, input int p);
    exp_t e;
    bit   rng, perr;
    int   lvl;
    classify(h, p, rng, perr, lvl);
    e.strb = {!(rng || perr), rng, perr};
    e.lvl  = (rng || perr) ? model_level : lvl;
    model_level = e.lvl;
    e.h    = h;
    e.p    = p;
    e.lock = !(rng || perr);
    e.due  = edge_cnt + LAT;
    sb.push_back(e);
  endtask

  task automatic rise_edge();
    if (pend_v) push_exp(pend_h, pend_p);
    pwm_in    = 1'b1;
    last_rise = edge_cnt;
  endtask

  task automatic frame(input int h, input int p);
    rise_edge();
    pend_v = 1'b1;
    pend_h = h;
    pend_p = p;
    repeat (TD * h) @(negedge clk);
    pwm_in = 1'b0;
    repeat (TD * (p - h)) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_level"}, level == 4'd0, level, 0);
    check({tag, "_pulse"}, pulse_us == 12'd0, pulse_us, 0);
    check({tag, "_period"}, period_us == 15'd0, period_us, 0);
    check({tag, "_strobes"}, {level_valid, err_range, err_period} == 3'b000,
          {level_valid, err_range, err_period}, 0);
    check({tag, "_timeout"}, timeout == 1'b0, timeout, 0);
    check({tag, "_locked"}, locked == 1'b0, locked, 0);
  endtask

  // Monitor: every strobe pops one expected frame result.
  always @(negedge clk) begin
    logic [2:0] st;
    exp_t e;
    st = {level_valid, err_range, err_period};
    if (st != 3'b000) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 1'b0, st, 0);
      end else begin
        e = sb.pop_front();
        check("strobe_kind", st == e.strb, st, e.strb);
        check("level", level == 4'(e.lvl), level, e.lvl);
        check("pulse_us", absdiff(pulse_us, e.h) <= 1, pulse_us, e.h);
        check("period_us", absdiff(period_us, e.p) <= 1, period_us, e.p);
        check("locked", locked == e.lock, locked, e.lock);
        check("latency", absdiff(edge_cnt, e.due) <= 1, edge_cnt, e.due);
      end
    end else if (sb.size() > 0 && edge_cnt > sb[0].due + 2) begin
      e = sb.pop_front();
      check("missing_strobe", 1'b0, edge_cnt, e.due);
    end
  end

  initial begin
    int h, p, t0;
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset");
    repeat (50) @(negedge clk);

    // Lock at level 8, sweep rounding boundaries, range and period faults.
    repeat (3) frame(164, PER);
    frame(100, PER); frame(220, PER); frame(102, PER); frame(106, PER);
    frame(164, PER); frame(240, PER); frame(164, PER);
    frame(164, 200); frame(164, 439); frame(164, 442); frame(164, PER);

    for (int i = 0; i < 25; i++) begin
      do begin
        h = $urandom_range(85, 245);
        p = $urandom_range(330, 470);
      end while (!stable(h, p) || (p - h) < 20);
      frame(h, p);
    end

    // Timeout: last frame never completes, line stays low.
    frame(164, PER); frame(164, PER); frame(164, PER);
    pend_v = 1'b0;
    t0 = last_rise;
    while (timeout == 1'b0 && (edge_cnt - t0) < 2 * PER * TD + 200) @(negedge clk);
    check("timeout_set", timeout == 1'b1, timeout, 1);
    check("timeout_time", absdiff(edge_cnt - t0, 2 * PER * TD + 3) <= 4,
          edge_cnt - t0, 2 * PER * TD + 3);
    check("timeout_locked", locked == 1'b0, locked, 0);
    check("timeout_level", level == 4'(model_level), level, model_level);
    rise_edge();
    pend_v = 1'b1; pend_h = 164; pend_p = PER;
    repeat (6) @(negedge clk);
    check("timeout_clear", timeout == 1'b0, timeout, 0);
    repeat (TD * 164 - 6) @(negedge clk);
    pwm_in = 1'b0;
    repeat (TD * (PER - 164)) @(negedge clk);
    frame(164, PER); frame(220, PER);

    // Reset while the line is high: decoder must wait for fall then rise.
    rise_edge();
    pend_v = 1'b1; pend_h = 164; pend_p = PER;
    repeat (60) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    pend_v = 1'b0;
    model_level = 0;
    @(negedge clk);
    check_zero("midreset");
    repeat (100) @(negedge clk);
    pwm_in = 1'b0;
    repeat (300) @(negedge clk);
    frame(164, PER); frame(164, PER); frame(106, PER);

    repeat (LAT + 40) @(negedge clk);
    check("queue_drained", sb.size() == 0, sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
